odometry_ctrl: RTL
==================

// Module: odometry_ctrl
// PURPOSE
//  Sequences minibot odometry between the two quadrature decoders and the Pi SPI link.
//  Every sample period it snapshots both free-running signed tick counters atomically.
//  It computes biased per-period deltas and serves them to the Pi through a command/response handshake.
//  Sits between the encoder decoders, the spi_slave word interface and the top level (MyDE0_Nano).
// PARAMETERS
//  PERIOD_CYCLES  1_000_000     sample period in clk cycles (20 ms @ 50 MHz)
//  BIAS           32'h7FFF_FFFF added to each signed delta so the Pi receives an unsigned value
//  WDOG_CYCLES    5_000_000     watchdog timeout in clk cycles (100 ms); used only with ODO_WATCHDOG_EN
// PORTS
//  clk          in   1   system clock, CLOCK_50
//  reset        in   1   synchronous, active-high reset
//  left_count   in   32  free-running signed tick count, left decoder; same clk domain
//  right_count  in   32  free-running signed tick count, right decoder; same clk domain
//  cmd_valid    in   1   one-cycle pulse: cmd_word holds a complete SPI word, already synchronised to clk
//  cmd_word     in   32  word received from the Pi
//  tx_load      out  1   one-cycle pulse: tx_word must be loaded into the spi_slave shift register
//  tx_word      out  32  response word
//  sample_tick  out  1   one-cycle pulse on each snapshot
//  motor_stop   out  1   watchdog trip flag; constant 0 when ODO_WATCHDOG_EN is undefined
// BEHAVIOUR
//  Reset values:
//   - tx_load = 0, sample_tick = 0, tx_word = 0, motor_stop = 0.
//   - Period counter = 0, prev_l = prev_r = 0.
//   - dl = dr = BIAS, seq = 0, sticky flags = 0, FSM = IDLE.
//  Period counter:
//   - Counts 0 .. PERIOD_CYCLES-1, then wraps to 0.
//   - sample_tick is asserted in the cycle the counter is at PERIOD_CYCLES-1.
//  Snapshot, on the sample_tick cycle (registered next edge):
//   - dl = left_count - prev_l + BIAS; dr = right_count - prev_r + BIAS. All arithmetic is 32-bit modular.
//   - prev_* <= *_count.
//   - seq <= seq+1 (16-bit; 0xFFFF wraps to 0).
//   - ovf flag is set if either signed delta overflows 32-bit signed arithmetic.
//  FSM states: IDLE -> DECODE -> RESPOND -> IDLE.
//   - IDLE: cmd_valid latches cmd_word[7:0] and moves to DECODE.
//   - DECODE: selects the response word.
//   - RESPOND: drives tx_word and pulses tx_load for exactly 1 cycle.
//   - Latency: cmd_valid at cycle N -> tx_load at N+2.
//  Command codes in cmd_word[7:0]; bits [31:8] are ignored:
//   - 0x00 NOP: responds 0x0000_0000.
//   - 0x01: responds dl.
//   - 0x02: responds dr.
//   - 0x03 STATUS: responds {seq[15:0], 12'b0, wdog, ovf, overrun, badcmd}, then clears all four sticky flags.
//     A flag event in the same cycle as the clear wins (flag remains set).
//   - Any other code: responds 32'hFFFF_FFFF and sets badcmd.
//  Boundary conditions:
//   - cmd_valid while the FSM is not IDLE: the command is dropped, overrun is set, and no extra tx_load occurs.
//   - Snapshot in the same cycle as DECODE: the response uses the pre-snapshot dl/dr; the new values are visible to the next command.
//   - Snapshot during IDLE or RESPOND has no interaction with the response.
//   - reset asserted mid-transaction: the FSM returns to IDLE, the pending tx_load is cancelled, and all registers take reset values.
// CONFIGURATION
//  ODO_WATCHDOG_EN defined:
//   - A counter is cleared by every accepted command of code 0x01-0x03.
//   - On reaching WDOG_CYCLES-1 it sets motor_stop=1 and the sticky wdog flag; the counter saturates.
//   - motor_stop clears on the next accepted command of code 0x01-0x03; the wdog flag clears only on STATUS.
//  ODO_WATCHDOG_EN undefined: no watchdog logic; motor_stop tied to 0 and the wdog status bit reads 0.
// TESTING (bench uses PERIOD_CYCLES=100, WDOG_CYCLES=500)
//  1. Reset held 3 cycles, then released with no commands -> tx_load=0, first sample_tick at cycle 99, seq=1 after it.
//  2. left_count steps 0 -> +25 and right_count steps 0 -> -10 before the tick; send 0x01 then 0x02
//     -> 0x8000_0018 and 0x7FFF_FFF5, each with tx_load at N+2.
//  3. Send 0x01, then 0x02 one cycle later -> single response (dl); STATUS read then returns bit1 (overrun)=1;
//     a second STATUS returns bit1=0.
//  4. Send 0x01 so that its DECODE lands on the sample_tick cycle -> old dl returned; a following 0x01 returns the new dl.
//  5. Send code 0x7E -> 0xFFFF_FFFF, and the next STATUS has bit0=1; assert reset on the RESPOND-1 cycle -> no tx_load.
//  6. (ODO_WATCHDOG_EN) Idle 500 cycles -> motor_stop=1; 0x01 accepted -> motor_stop=0; STATUS bit3=1.

Source files
------------

// File: rtl/odometry_ctrl.sv
// Odometry sequencer: periodic atomic snapshot of both wheel tick counters, biased deltas,
// and a command/response engine for the SPI link. Define ODO_WATCHDOG_EN to add the comms watchdog.
module odometry_ctrl #(
   parameter int unsigned PERIOD_CYCLES = 1_000_000,
   parameter logic [31:0] BIAS          = 32'h7FFF_FFFF,
   parameter int unsigned WDOG_CYCLES   = 5_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] left_count,
   input  logic [31:0] right_count,
   input  logic        cmd_valid,
   input  logic [31:0] cmd_word,
   output logic        tx_load,
   output logic [31:0] tx_word,
   output logic        sample_tick,
   output logic        motor_stop
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DECODE  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam logic [7:0]  CMD_NOP     = 8'h00;
   localparam logic [7:0]  CMD_DL      = 8'h01;
   localparam logic [7:0]  CMD_DR      = 8'h02;
   localparam logic [7:0]  CMD_STATUS  = 8'h03;
   localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYCLES - 32'd1);

   // Signed overflow of a - b in 32-bit two's complement
   function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      d = a - b;
      return (a[31] != b[31]) && (d[31] != a[31]);
   endfunction

   function automatic logic [31:0] biased_delta(input logic [31:0] cur, input logic [31:0] prev);
      return cur - prev + BIAS;
   endfunction

   state_t      state_r, state_next_s;
   logic [31:0] period_cnt_r, period_next_s;
   logic        sample_tick_r;
   logic [31:0] prev_left_r, prev_right_r;
   logic [31:0] dl_r, dr_r;
   logic [15:0] seq_r;
   logic        ovf_r, overrun_r, badcmd_r;
   logic [7:0]  cmd_code_r;
   logic        tx_load_r;
   logic [31:0] tx_word_r;

   logic        accept_s;
   logic        overrun_set_s;
   logic        badcmd_set_s;
   logic        ovf_set_s;
   logic        status_clr_s;
   logic        wdog_s;
   logic [31:0] resp_s;
   logic        unused_s;

   assign unused_s    = ^{cmd_word[31:8], 32'(WDOG_CYCLES)};
   assign tx_load     = tx_load_r;
   assign tx_word     = tx_word_r;
   assign sample_tick = sample_tick_r;
   assign ovf_set_s   = sample_tick_r &
                        (sub_ovf(left_count, prev_left_r) | sub_ovf(right_count, prev_right_r));

   // Next value of the sample period counter
   always_comb begin
      period_next_s = 32'd0;
      if (period_cnt_r == PERIOD_LAST) begin
         period_next_s = 32'd0;
      end else begin
         period_next_s = period_cnt_r + 32'd1;
      end
   end

   // Period counter; the tick register goes high exactly while the counter sits at its last value
   always_ff @(posedge clk) begin
      if (reset) begin
         period_cnt_r  <= 32'd0;
         sample_tick_r <= 1'b0;
      end else begin
         period_cnt_r  <= period_next_s;
         sample_tick_r <= (period_next_s == PERIOD_LAST);
      end
   end

   // Atomic snapshot of both counters on the tick cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_left_r  <= 32'd0;
         prev_right_r <= 32'd0;
         dl_r         <= BIAS;
         dr_r         <= BIAS;
         seq_r        <= 16'd0;
      end else if (sample_tick_r) begin
         prev_left_r  <= left_count;
         prev_right_r <= right_count;
         dl_r         <= biased_delta(left_count, prev_left_r);
         dr_r         <= biased_delta(right_count, prev_right_r);
         seq_r        <= seq_r + 16'd1;
      end
   end

   // Command FSM next state and response selection
   always_comb begin
      state_next_s  = state_r;
      accept_s      = 1'b0;
      overrun_set_s = 1'b0;
      badcmd_set_s  = 1'b0;
      status_clr_s  = 1'b0;
      resp_s        = 32'h0000_0000;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               accept_s     = 1'b1;
               state_next_s = DECODE;
            end else begin
               state_next_s = IDLE;
            end
         end
         DECODE: begin
            state_next_s  = RESPOND;
            overrun_set_s = cmd_valid;
            case (cmd_code_r)
               CMD_NOP:    resp_s = 32'h0000_0000;
               CMD_DL:     resp_s = dl_r;
               CMD_DR:     resp_s = dr_r;
               CMD_STATUS: begin
                  resp_s       = {seq_r, 12'h000, wdog_s, ovf_r, overrun_r, badcmd_r};
                  status_clr_s = 1'b1;
               end
               default: begin
                  resp_s       = 32'hFFFF_FFFF;
                  badcmd_set_s = 1'b1;
               end
            endcase
         end
         RESPOND: begin
            state_next_s  = IDLE;
            overrun_set_s = cmd_valid;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM state, latched command code and the registered response port
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         cmd_code_r <= 8'h00;
         tx_load_r  <= 1'b0;
         tx_word_r  <= 32'h0000_0000;
      end else begin
         state_r   <= state_next_s;
         tx_load_r <= (state_r == DECODE);
         if (accept_s) begin
            cmd_code_r <= cmd_word[7:0];
         end
         if (state_r == DECODE) begin
            tx_word_r <= resp_s;
         end
      end
   end

   // Sticky status flags: a set in the same cycle as a STATUS clear keeps the flag
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_r     <= 1'b0;
         overrun_r <= 1'b0;
         badcmd_r  <= 1'b0;
      end else begin
         ovf_r     <= (ovf_r & ~status_clr_s) | ovf_set_s;
         overrun_r <= (overrun_r & ~status_clr_s) | overrun_set_s;
         badcmd_r  <= (badcmd_r & ~status_clr_s) | badcmd_set_s;
      end
   end

`ifdef ODO_WATCHDOG_EN
   localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 32'd1);

   logic [31:0] wdog_cnt_r;
   logic        motor_stop_r;
   logic        wdog_r;
   logic        cmd_ok_s;
   logic        wdog_trip_s;

   assign cmd_ok_s    = accept_s && (cmd_word[7:0] >= CMD_DL) && (cmd_word[7:0] <= CMD_STATUS);
   assign wdog_trip_s = (wdog_cnt_r == WDOG_LAST);
   assign motor_stop  = motor_stop_r;
   assign wdog_s      = wdog_r;

   // Watchdog: any data/status command feeds it; once expired it saturates and holds motor_stop
   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_cnt_r   <= 32'd0;
         motor_stop_r <= 1'b0;
         wdog_r       <= 1'b0;
      end else begin
         if (cmd_ok_s) begin
            wdog_cnt_r   <= 32'd0;
            motor_stop_r <= 1'b0;
         end else if (wdog_trip_s) begin
            motor_stop_r <= 1'b1;
         end else begin
            wdog_cnt_r <= wdog_cnt_r + 32'd1;
         end
         wdog_r <= (wdog_r & ~status_clr_s) | wdog_trip_s;
      end
   end
`else
   assign motor_stop = 1'b0;
   assign wdog_s     = 1'b0;
`endif

endmodule
